// File: rtl/wash_seq_ctrl.sv
// Wash job sequencer: fill/agitate/drain rounds (wash + N rinses) then spin, paced by a
// 1 s tick prescaler, with pause/resume and abort. Optional door interlock: `DOOR_LOCK_EN.
module wash_seq_ctrl #(
   parameter int TICK_DIV = 100_000_000,
   parameter int WASH_S   = 5,
   parameter int RINSE_S  = 2,
   parameter int SPIN_S   = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [2:0] i_mode,
   input  logic       i_pause_pos,
   input  logic       i_abort,
   input  logic       i_ack,
   output logic       o_busy,
   output logic       o_done,
   output logic [2:0] o_phase,
   output logic [7:0] o_st_light,
   output logic [7:0] o_wt_light,
   output logic [7:0] o_sec_left,
   output logic [1:0] o_round
`ifdef DOOR_LOCK_EN
   ,
   input  logic       i_door_closed,
   output logic       o_door_lock
`endif
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      AGIT  = 3'd2,
      DRAIN = 3'd3,
      SPIN  = 3'd4,
      DONE  = 3'd5,
      PAUSE = 3'd6
   } phase_t;

   function automatic logic [7:0] f_scale(input int unsigned base, input logic [1:0] k);
      return 8'(base * k);
   endfunction

   phase_t          r_phase, w_phase_nxt;
   phase_t          r_saved, w_saved_nxt;
   logic [PW-1:0]   r_presc, w_presc_nxt;
   logic [7:0]      r_wt, w_wt_nxt;
   logic [7:0]      r_sec, w_sec_nxt;
   logic [1:0]      r_round, w_round_nxt;
   logic [1:0]      r_k, w_k_nxt;
   logic [1:0]      r_rinse, w_rinse_nxt;

   logic            w_busy;
   logic            w_run;
   logic            w_tick;
   logic            w_start_ok;
   logic            w_pause_req;
   logic            w_resume_ok;

`ifdef DOOR_LOCK_EN
   logic            r_door_q;
   // An opening door behaves like a pause press; a paused job stays put until it closes.
   assign w_start_ok  = i_start & i_door_closed;
   assign w_pause_req = i_pause_pos | (r_door_q & ~i_door_closed);
   assign w_resume_ok = i_door_closed;
`else
   assign w_start_ok  = i_start;
   assign w_pause_req = i_pause_pos;
   assign w_resume_ok = 1'b1;
`endif

   assign w_busy = (r_phase != IDLE) && (r_phase != DONE);
   assign w_run  = w_busy && (r_phase != PAUSE);
   assign w_tick = w_run && (r_presc == PRESC_MAX);

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_phase <= IDLE;
         r_saved <= IDLE;
         r_presc <= '0;
         r_wt    <= '0;
         r_sec   <= '0;
         r_round <= '0;
         r_k     <= 2'd1;
         r_rinse <= 2'd1;
`ifdef DOOR_LOCK_EN
         r_door_q <= 1'b0;
`endif
      end else begin
         r_phase <= w_phase_nxt;
         r_saved <= w_saved_nxt;
         r_presc <= w_presc_nxt;
         r_wt    <= w_wt_nxt;
         r_sec   <= w_sec_nxt;
         r_round <= w_round_nxt;
         r_k     <= w_k_nxt;
         r_rinse <= w_rinse_nxt;
`ifdef DOOR_LOCK_EN
         r_door_q <= i_door_closed;
`endif
      end
   end

   // Next-state and datapath
   always_comb begin
      w_phase_nxt = r_phase;
      w_saved_nxt = r_saved;
      w_presc_nxt = r_presc;
      w_wt_nxt    = r_wt;
      w_sec_nxt   = r_sec;
      w_round_nxt = r_round;
      w_k_nxt     = r_k;
      w_rinse_nxt = r_rinse;

      if (w_run)
         w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);

      case (r_phase)
         IDLE: begin
            if (w_start_ok) begin
               w_presc_nxt = '0;
               w_round_nxt = 2'd0;
               w_wt_nxt    = 8'h00;
               w_sec_nxt   = 8'h00;
               case (i_mode)
                  3'd0:    begin w_k_nxt = 2'd1; w_rinse_nxt = 2'd1; end
                  3'd2:    begin w_k_nxt = 2'd3; w_rinse_nxt = 2'd3; end
                  3'd3:    begin w_k_nxt = 2'd3; w_rinse_nxt = 2'd0; end
                  default: begin w_k_nxt = 2'd2; w_rinse_nxt = 2'd2; end
               endcase
               if (i_mode == 3'd3) begin
                  w_phase_nxt = SPIN;
                  w_sec_nxt   = f_scale(SPIN_S, 2'd3);
               end else begin
                  w_phase_nxt = FILL;
               end
            end
         end
         FILL: begin
            if (w_tick) begin
               w_wt_nxt = {r_wt[6:0], 1'b1};
               if (r_wt[6:0] == 7'h7F) begin
                  w_phase_nxt = AGIT;
                  w_sec_nxt   = (r_round == 2'd0) ? f_scale(WASH_S, r_k) : 8'(RINSE_S);
               end
            end
         end
         AGIT: begin
            if (w_tick) begin
               w_sec_nxt = r_sec - 8'd1;
               if (r_sec == 8'd1)
                  w_phase_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_tick) begin
               w_wt_nxt = {1'b0, r_wt[7:1]};
               if (r_wt[7:1] == 7'h00) begin
                  if (r_round < r_rinse) begin
                     w_round_nxt = r_round + 2'd1;
                     w_phase_nxt = FILL;
                  end else begin
                     w_phase_nxt = SPIN;
                     w_sec_nxt   = f_scale(SPIN_S, r_k);
                  end
               end
            end
         end
         SPIN: begin
            if (w_tick) begin
               w_sec_nxt = r_sec - 8'd1;
               if (r_sec == 8'd1)
                  w_phase_nxt = DONE;
            end
         end
         DONE: begin
            if (i_ack) begin
               w_phase_nxt = IDLE;
               w_round_nxt = 2'd0;
               w_wt_nxt    = 8'h00;
               w_sec_nxt   = 8'h00;
            end
         end
         PAUSE: begin
            if (i_pause_pos && w_resume_ok)
               w_phase_nxt = r_saved;
         end
         default: w_phase_nxt = IDLE;
      endcase

      // Pause lands after this cycle's tick, so the saved phase is the post-tick one.
      if (w_run && w_pause_req) begin
         w_saved_nxt = w_phase_nxt;
         w_phase_nxt = PAUSE;
      end

      if (i_abort && (r_phase != IDLE)) begin
         w_phase_nxt = IDLE;
         w_saved_nxt = IDLE;
         w_presc_nxt = '0;
         w_wt_nxt    = 8'h00;
         w_sec_nxt   = 8'h00;
         w_round_nxt = 2'd0;
      end
   end

   // Outputs
   always_comb begin
      o_busy     = w_busy;
      o_done     = (r_phase == DONE);
      o_phase    = r_phase;
      o_st_light = 8'h01 << r_phase;
      o_wt_light = r_wt;
      o_sec_left = r_sec;
      o_round    = r_round;
`ifdef DOOR_LOCK_EN
      o_door_lock = w_busy && ((r_phase != PAUSE) || (r_wt != 8'h00));
`endif
   end

endmodule
